tipi_rpi_shift_link: RTL

//  Serial link between the TI-side latch registers and the Raspberry Pi GPIO.

---
 rtl/tipi_pkg.sv | 29 ++
 rtl/tipi_rpi_shift_link_if.sv | 41 ++++
 rtl/tipi_sync_edge.sv | 37 +++
 rtl/tipi_rpi_shift_link.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tipi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tipi_pkg
//  Description : Shared constants and types for the TIPI Raspberry Pi shift
//                link: default register width, register-select codes and
//                FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package tipi_pkg;

    // The Pi protocol moves whole bytes.
    localparam int TIPI_WIDTH = 8;

    // Register select codes carried on r_sel at the r_le edge.
    localparam logic [1:0] SEL_TD = 2'b00;
    localparam logic [1:0] SEL_TC = 2'b01;
    localparam logic [1:0] SEL_RD = 2'b10;
    localparam logic [1:0] SEL_RC = 2'b11;

    // IDLE means "no TD/TC load since the last RD/RC commit"; shifting is
    // accepted in every state.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_SHIFT  = 2'd2
    } tipi_state_e;

endpackage
`default_nettype wire

// File: rtl/tipi_rpi_shift_link_if.sv
`default_nettype none
// ============================================================================
//  Module      : tipi_rpi_shift_link_if
//  Description : Signal bundle between the TI latch stage / Raspberry Pi pins
//                and the shift link.
//                master : drives the TI bytes and Pi pins, reads results
//                slave  : the shift link itself
//  Ports       : ti_td, ti_tc  TI data / control bytes (async)
//                r_clk, r_le   Pi shift clock / latch enable (async)
//                r_sel, r_din  Pi register select / serial data in
//                r_dout        serial data to the Pi
//                rd_q, rc_q    Pi data / control bytes for TI readback
//                bit_cnt       shifts since the last r_le edge
//  Revision    : 1.0 - initial release
// ============================================================================
interface tipi_rpi_shift_link_if #(
    parameter int WIDTH = tipi_pkg::TIPI_WIDTH
);
    logic [WIDTH-1:0] ti_td;
    logic [WIDTH-1:0] ti_tc;
    logic             r_clk;
    logic             r_le;
    logic [1:0]       r_sel;
    logic             r_din;
    logic             r_dout;
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] rc_q;
    logic [3:0]       bit_cnt;

    modport master (
        output ti_td, ti_tc, r_clk, r_le, r_sel, r_din,
        input  r_dout, rd_q, rc_q, bit_cnt
    );

    modport slave (
        input  ti_td, ti_tc, r_clk, r_le, r_sel, r_din,
        output r_dout, rd_q, rc_q, bit_cnt
    );

endinterface
`default_nettype wire

// File: rtl/tipi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : tipi_sync_edge
//  Description : One-bit multi-flop synchronizer with rising-edge detect.
//                rise_o pulses for one clk, SYNC_STAGES clk after the pin
//                edge is first sampled, so the consumer acts on it at
//                SYNC_STAGES+1 clk.
//  Ports       : clk, rst_n (async active-low), d_i (async pin),
//                rise_o (one-cycle rise pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module tipi_sync_edge #(
    parameter int SYNC_STAGES = 2     // must be >= 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/tipi_rpi_shift_link.sv
`default_nettype none
// ============================================================================
//  Module      : tipi_rpi_shift_link
//  Description : Serial link between the TI latch registers and the Pi GPIO.
//                Synchronizes TI bytes and Pi strobes into clk, filters torn
//                TI writes, shifts TD/TC out and RD/RC in.
//  Ports       : clk    50 MHz system clock
//                rst_n  asynchronous active-low reset
//                link   tipi_rpi_shift_link_if.slave (TI bytes, Pi pins,
//                       rd_q/rc_q readback bytes, bit_cnt)
//  Revision    : 1.0 - initial release
// ============================================================================
module tipi_rpi_shift_link
    import tipi_pkg::*;
#(
    parameter int WIDTH       = TIPI_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    tipi_rpi_shift_link_if.slave        link
);

    localparam int DW = 2 * WIDTH + 3;               // td, tc, sel, din
    localparam int CW = $clog2(STABLE_CNT + 1);

    // ---------------------------------------------------------------- sync
    logic w_clk_rise;
    logic w_le_rise;

    tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (link.r_clk),
        .rise_o (w_clk_rise)
    );

    tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_le (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (link.r_le),
        .rise_o (w_le_rise)
    );

    // Data bits share the same depth as the strobes, so at the action edge
    // r_sel/r_din reflect the pins sampled together with the strobe edge.
    logic [DW-1:0]    data_sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] w_td_sync;
    logic [WIDTH-1:0] w_tc_sync;
    logic [1:0]       w_sel_sync;
    logic             w_din_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
        end else begin
            data_sync_q[0] <= {link.ti_td, link.ti_tc, link.r_sel, link.r_din};
            for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
        end
    end

    assign {w_td_sync, w_tc_sync, w_sel_sync, w_din_sync} = data_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------ stability filter
    // A snapshot updates only once the synced byte has matched its previous
    // sample for STABLE_CNT consecutive cycles, so a multi-bit TI write that
    // lands across sync boundaries never reaches sr.
    logic [WIDTH-1:0] w_stab_in [2];
    logic [WIDTH-1:0] w_snap    [2];

    assign w_stab_in[0] = w_td_sync;
    assign w_stab_in[1] = w_tc_sync;

    for (genvar g = 0; g < 2; g++) begin : g_stab
        logic [WIDTH-1:0] last_q;
        logic [WIDTH-1:0] snap_q;
        logic [CW-1:0]    cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                last_q <= '0;
                snap_q <= '0;
                cnt_q  <= '0;
            end else begin
                last_q <= w_stab_in[g];
                if (w_stab_in[g] != last_q) begin
                    cnt_q <= '0;
                end else if (cnt_q != CW'(STABLE_CNT)) begin
                    cnt_q <= cnt_q + CW'(1);
                end else begin
                    snap_q <= last_q;
                end
            end
        end

        assign w_snap[g] = snap_q;
    end

    // ------------------------------------------------------------------ FSM
    tipi_state_e      state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] rd_byte_q, rd_byte_d;
    logic [WIDTH-1:0] rc_byte_q, rc_byte_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            rd_byte_q <= '0;
            rc_byte_q <= '0;
            cnt_q     <= '0;
            dout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            rd_byte_q <= rd_byte_d;
            rc_byte_q <= rc_byte_d;
            cnt_q     <= cnt_d;
            dout_q    <= sr_q[WIDTH-1];
        end
    end

    // r_le has priority: a coincident r_clk rise is dropped and bit_cnt
    // reading 0 is how the Pi side detects that.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        rd_byte_d = rd_byte_q;
        rc_byte_d = rc_byte_q;
        cnt_d     = cnt_q;
        if (w_le_rise) begin
            cnt_d = 4'd0;
            unique case (w_sel_sync)
                SEL_TD: begin
                    sr_d    = w_snap[0];
                    state_d = ST_LOADED;
                end
                SEL_TC: begin
                    sr_d    = w_snap[1];
                    state_d = ST_LOADED;
                end
                SEL_RD: begin
                    rd_byte_d = sr_q;
                    state_d   = ST_IDLE;
                end
                SEL_RC: begin
                    rc_byte_d = sr_q;
                    state_d   = ST_IDLE;
                end
            endcase
        end else if (w_clk_rise) begin
            sr_d    = {sr_q[WIDTH-2:0], w_din_sync};
            cnt_d   = (cnt_q == 4'(WIDTH)) ? cnt_q : cnt_q + 4'd1;
            state_d = ST_SHIFT;
        end
    end

    assign link.r_dout  = dout_q;
    assign link.rd_q    = rd_byte_q;
    assign link.rc_q    = rc_byte_q;
    assign link.bit_cnt = cnt_q;

endmodule
`default_nettype wire
